// File: rtl/line_sram_arbiter_if.sv
// rtl/line_sram_arbiter_if.sv - read-requester and SRAM bus bundle for line_sram_arbiter
interface line_sram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 18
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  sram_cs;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  rd_req, rd_addr, sram_rdata,
    output rd_gnt, rd_valid, rd_data, sram_cs, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output rd_req, rd_addr, sram_rdata,
    input  rd_gnt, rd_valid, rd_data, sram_cs, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/line_sram_arbiter.sv
// rtl/line_sram_arbiter.sv - shares one single-port SRAM between a raster pixel writer and a random reader
module line_sram_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 18,
  parameter int WIDTH_IMAG  = 384,
  parameter int HEIGHT_IMAG = 512,
  parameter int FIFO_DEPTH  = 4,
  parameter int HI_WM       = 3
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          i_hav,
  input  logic                          i_vav,
  input  logic [DATA_WIDTH-1:0]         i_data,
  line_sram_arbiter_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_frame_done,
  output logic                          o_ovf
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH_IMAG * HEIGHT_IMAG - 1);

  localparam logic [1:0] WAIT_FRAME = 2'd0;
  localparam logic [1:0] ACTIVE     = 2'd1;
  localparam logic [1:0] FLUSH      = 2'd2;

  logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_cnt, r_old_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [1:0]            r_state;
  logic                  r_vav_d, r_rd_valid, r_frame_done, r_ovf;

  logic                  w_vav_rise, w_vav_fall, w_push, w_full, w_empty, w_push_ok;
  logic                  w_rd, w_pop;
  logic [ADDR_WIDTH-1:0] w_push_addr;
  logic [CW-1:0]         w_cnt_next, w_old_next;

  assign w_vav_rise  = i_vav & ~r_vav_d;
  assign w_vav_fall  = ~i_vav & r_vav_d;
  assign w_push      = i_hav & i_vav;
  assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_push_ok   = w_push & ~w_full;
  assign w_push_addr = w_vav_rise ? '0 : r_wr_addr;

  // Reads win while the buffer is shallow; rstb gating keeps the SRAM quiet during reset.
  assign w_rd  = rstb & bus.rd_req & (w_empty | ((r_cnt < CW'(HI_WM)) & (r_state != FLUSH)));
  assign w_pop = ~w_rd & ~w_empty;

  assign w_cnt_next = r_cnt + CW'(w_push_ok) - CW'(w_pop);
  assign w_old_next = r_old_cnt - CW'(w_pop && (r_old_cnt != '0));

  assign bus.rd_gnt     = w_rd;
  assign bus.sram_cs    = w_rd | w_pop;
  assign bus.sram_we    = w_pop;
  assign bus.sram_addr  = w_rd ? bus.rd_addr : (w_pop ? r_fifo_addr[r_rptr] : '0);
  assign bus.sram_wdata = w_pop ? r_fifo_data[r_rptr] : '0;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_valid ? bus.sram_rdata : '0;

  assign o_fifo_cnt   = r_cnt;
  assign o_frame_done = r_frame_done;
  assign o_ovf        = r_ovf;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_addr[r_wptr] <= w_push_addr;
      r_fifo_data[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_wr_addr  <= '0;
      r_vav_d    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_vav_d    <= i_vav;
      r_rd_valid <= w_rd;
      r_cnt      <= w_cnt_next;
      if (w_push & w_full) r_ovf <= 1'b1;
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      // A dropped pixel still consumes its address so the raster stays aligned.
      if (w_push) r_wr_addr <= (w_push_addr == LAST_ADDR) ? '0 : w_push_addr + 1'b1;
      else if (w_vav_rise) r_wr_addr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= WAIT_FRAME;
      r_old_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT_FRAME: if (w_vav_rise) r_state <= ACTIVE;
        ACTIVE: begin
          if (w_vav_fall) begin
            r_state   <= FLUSH;
            r_old_cnt <= w_cnt_next;
          end
        end
        FLUSH: begin
          // Old-frame entries sit at the FIFO head, so each pop retires one of them first.
          r_old_cnt <= w_old_next;
          if (w_old_next == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= i_vav ? ACTIVE : WAIT_FRAME;
          end
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end
endmodule

// File: doc/line_sram_arbiter.md
Name: line_sram_arbiter

Overview:
- Shares one single-port, synchronous-read SRAM between two requesters: the raster pixel write stream from rgb2gray (qualified by hav/vav) and a random-access read requester, such as a Filter_2-style window fetch.
- Incoming pixels are buffered in a small {addr,data} write FIFO so that reads can be slotted between writes.
- Write addresses are generated internally per frame.
- Sits between the colour-conversion stage and the SRAM macro.

Parameters:
- DATA_WIDTH, 8, pixel and SRAM word width
- ADDR_WIDTH, 18, SRAM address width
- WIDTH_IMAG, 384, pixels per line
- HEIGHT_IMAG, 512, lines per frame
- FIFO_DEPTH, 4, write-buffer entries (power of 2, ≥2)
- HI_WM, 3, FIFO count at which writes take priority over reads (1 ≤ HI_WM ≤ FIFO_DEPTH-1)

Ports:
- clk  in  1  system clock, rising edge
- rstb  in  1  asynchronous active-low reset
- i_hav  in  1  horizontal active from upstream
- i_vav  in  1  vertical active from upstream
- i_data  in  DATA_WIDTH  pixel, valid when i_hav&i_vav
- rd_req  in  1  read request, held until granted
- rd_addr  in  ADDR_WIDTH  read address, stable while rd_req is high
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid, one cycle after rd_gnt
- rd_data  out  DATA_WIDTH  read data
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable (1=write)
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, one cycle after a read command
- o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_frame_done  out  1  one-cycle pulse when a frame is fully committed to SRAM
- o_ovf  out  1  sticky overflow error

Behaviour:
- Reset values: all outputs 0; FIFO empty; write address counter 0; state WAIT_FRAME.
- Write capture:
  - Each cycle with i_hav&i_vav pushes {wr_addr, i_data} into the FIFO, then wr_addr increments.
  - wr_addr wraps from WIDTH_IMAG*HEIGHT_IMAG-1 to 0.
  - wr_addr is cleared to 0 on every rising edge of i_vav; that cycle's pixel, if any, uses address 0.
- Push while the FIFO is full: the pixel is dropped, o_ovf is set and stays set until reset. Overflow cannot occur when HI_WM ≤ FIFO_DEPTH-1; the bench must check that o_ovf stays 0.
- Simultaneous push and pop: allowed; count is unchanged.
- Per-cycle arbitration (combinational, one SRAM access per cycle):
  - FIFO empty and rd_req: read.
  - rd_req and count < HI_WM and state ≠ FLUSH: read.
  - Otherwise, FIFO non-empty: write the FIFO head (pop).
  - Otherwise: idle (sram_cs=0).
- Read cycle drive: rd_gnt=1, sram_cs=1, sram_we=0, sram_addr=rd_addr.
- Write cycle drive: sram_cs=1, sram_we=1, sram_addr and sram_wdata from the FIFO head.
- Read data path: rd_valid is registered from rd_gnt. rd_data = sram_rdata, sampled in the rd_valid cycle. Read latency from gnt to data is 1 cycle.
- No write-to-read forwarding: a read of an address still in the FIFO returns the old SRAM contents. Requesters must not read the current line's unflushed pixels.
- Read starvation: reads may stall for the whole active line while count sits at HI_WM. They are guaranteed service during horizontal blanking.
- Frame FSM:
  - WAIT_FRAME → ACTIVE on i_vav rising.
  - ACTIVE → FLUSH on i_vav falling.
  - FLUSH: writes have priority over reads. When the FIFO becomes empty, o_frame_done pulses for 1 cycle. The next state is ACTIVE if i_vav=1 (a new frame started during the flush), else WAIT_FRAME.
  - Pixels arriving during FLUSH are pushed normally with the new frame's addresses. Only entries from the old frame gate o_frame_done: track an old-entry count.
- Reset mid-operation: FIFO contents are discarded, no SRAM access occurs, and the FSM restarts in WAIT_FRAME.

Test Plan:
- Single 4-pixel frame (i_hav&i_vav for 4 cycles, data 10,11,12,13), no reads:
  - SRAM writes to addr 0..3 with 10..13.
  - o_fifo_cnt peaks at 1.
  - o_frame_done pulses once, ≤2 cycles after i_vav falls.
- Read only, pre-loaded SRAM mem[5]=0xA5, rd_req with addr 5 in idle:
  - rd_gnt high the same cycle.
  - rd_valid=1 and rd_data=0xA5 the next cycle.
- Contention, rd_req held high during an active line:
  - First grants are reads until o_fifo_cnt=3 (HI_WM).
  - Writes then alternate such that count never exceeds 3.
  - Read is granted within 1 cycle of hav falling.
  - o_ovf=0 throughout.
- Full 384x512 frame from hav_vav_gen, then read back all addresses during blanking: every read returns the gray pixel written at i = line*384+col.
- Reset asserted while FIFO count=3:
  - All outputs are 0 immediately.
  - After release, a new frame writes starting from addr 0 with no stale writes.
- New frame starting while FLUSH still has 2 old entries:
  - o_frame_done pulses after exactly the 2 old writes.
  - FSM goes to ACTIVE.
  - New frame pixel 0 is written to addr 0.
